// File: rtl/eu_xbuf_multi.sv
// eu_xbuf_multi: fully-associative tagged operand buffer with NUM_REQ_PORTS lookup ports (peek or consume).
// Latency: lookups are combinational; writes and frees take effect at the next rising edge.
// Backpressure: in_ready_o drops when full or when the tag is already held; optional same-cycle bypass via EU_XBUF_MULTI_BYPASS_EN.
module eu_xbuf_multi #(
  parameter int NUM_IDX_BITS  = 2,
  parameter int NUM_REQ_PORTS = 2,
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [ADDR_W-1:0]                      in_addr_i,
  input  logic [DATA_W-1:0]                      in_data_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [NUM_REQ_PORTS-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ_PORTS-1:0]               req_valid_i,
  input  logic [NUM_REQ_PORTS-1:0]               req_consume_i,
  output logic [NUM_REQ_PORTS-1:0][DATA_W-1:0]   resp_data_o,
  output logic [NUM_REQ_PORTS-1:0]               resp_success_o,
  output logic [NUM_IDX_BITS:0]                  count_o,
  output logic                                   full_o,
  output logic                                   empty_o
);

  localparam int DEPTH = 2 ** NUM_IDX_BITS;
  localparam int IDX_W = NUM_IDX_BITS;
  localparam int CNT_W = NUM_IDX_BITS + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]             count_q, count_d;

  logic             dup_hit;
  logic [DEPTH-1:0] free_vec;
  logic             byp_consume;
  logic             alloc;
  logic [IDX_W-1:0] alloc_idx;
  logic [CNT_W-1:0] nfree;

  assign count_o = count_q;
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  // Gated by reset_n so the handshake reads low for the whole reset window.
  assign in_ready_o = reset_n & in_valid_i & ~full_o & ~dup_hit;

  // Detect an incoming tag that is already resident; duplicates wait until freed.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == in_addr_i)) dup_hit = 1'b1;
    end
  end

  // Per-port associative lookup; consuming hits mark their entry for release.
  always_comb begin
    resp_success_o = '0;
    resp_data_o    = '0;
    free_vec       = '0;
    byp_consume    = 1'b0;
    for (int p = 0; p < NUM_REQ_PORTS; p++) begin
      if (req_valid_i[p]) begin
        // Tags are unique among valid entries, so at most one entry matches.
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (tag_q[i] == req_addr_i[p])) begin
            resp_success_o[p] = 1'b1;
            resp_data_o[p]    = data_q[i];
            if (req_consume_i[p]) free_vec[i] = 1'b1;
          end
        end
`ifdef EU_XBUF_MULTI_BYPASS_EN
        // An accepted write never collides with a resident tag, so the bypass
        // cannot conflict with a stored hit on the same port.
        if (in_ready_o && (req_addr_i[p] == in_addr_i)) begin
          resp_success_o[p] = 1'b1;
          resp_data_o[p]    = in_data_i;
          if (req_consume_i[p]) byp_consume = 1'b1;
        end
`endif
      end
    end
  end

  // Pick the lowest-index free slot; a consumed bypass write is never stored.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
    alloc = in_ready_o & ~byp_consume;
  end

  // Next-state for the entry array and the occupancy counter.
  always_comb begin
    valid_d = valid_q & ~free_vec;
    tag_d   = tag_q;
    data_d  = data_q;
    nfree   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nfree = nfree + CNT_W'(free_vec[i]);
    end
    if (alloc) begin
      valid_d[alloc_idx] = 1'b1;
      tag_d[alloc_idx]   = in_addr_i;
      data_d[alloc_idx]  = in_data_i;
    end
    count_d = count_q - nfree + CNT_W'(alloc);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule
